// File: rtl/quickq_pkg.sv
// Shared constants and the decoded command type for QuickQ priority-queue nodes.
package quickq_pkg;

    localparam int KEY_W_DEF = 16;
    localparam int VAL_W_DEF = 16;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_WR,
        OP_RD,
        OP_RW
    } op_e;

endpackage

// File: rtl/pq_cmp.sv
// Key ordering primitive: precedes is 1 when key a belongs strictly ahead of key b.
module pq_cmp #(
    parameter int KEY_W     = 16,
    parameter int MIN_FIRST = 1
) (
    input  logic [KEY_W-1:0] a_key,
    input  logic [KEY_W-1:0] b_key,
    output logic             precedes
);

    // Strict compare: equal keys never precede, which keeps older entries ahead.
    assign precedes = (MIN_FIRST != 0) ? (a_key < b_key) : (a_key > b_key);

endmodule

// File: rtl/quick_node_p.sv
// One systolic priority-queue node holding DEPTH sorted entries, head in slot 0.
// Overflow spills the last entry to the right node; reads refill from the right head.
module quick_node_p
    import quickq_pkg::*;
#(
    parameter int KEY_W     = KEY_W_DEF,
    parameter int VAL_W     = VAL_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int MIN_FIRST = 1,
    localparam int W        = KEY_W + VAL_W,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_i,
    output logic          reset_o,
    input  logic          write_i,
    input  logic          read_i,
    input  logic [W-1:0]  data_lt_i,
    output logic [W-1:0]  data_lt_o,
    output logic          valid_lt_o,
    output logic [W-1:0]  data_rt_o,
    output logic          write_o,
    output logic          read_o,
    input  logic [W-1:0]  data_rt_i,
    input  logic          valid_rt_i,
    output logic          ready_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          err_o
);

    // Handshake: write_i/read_i are taken only in a cycle where ready_o is high;
    // an accepted command drops ready_o for exactly the next cycle, and any
    // command presented while ready_o is low is dropped and latches err_o.

    logic [W-1:0]  slot_q [DEPTH];
    logic [W-1:0]  slot_d [DEPTH];
    logic [W-1:0]  base   [DEPTH];
    logic [W-1:0]  ins    [DEPTH+1];
    logic [DEPTH-1:0] new_first;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  rt_q, rt_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d, err_set;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic          rst_q;
    op_e           op;
    int            cnt, base_cnt, pos, cnt_n;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        pq_cmp #(
            .KEY_W     (KEY_W),
            .MIN_FIRST (MIN_FIRST)
        ) u_cmp (
            .a_key    (data_lt_i[W-1 -: KEY_W]),
            .b_key    (base[g][W-1 -: KEY_W]),
            .precedes (new_first[g])
        );
    end

    // Decode the command and form the entry set the new key is inserted into.
    always_comb begin
        cnt      = int'(count_q);
        op       = OP_NOP;
        err_set  = 1'b0;
        base_cnt = cnt;
        if (write_i || read_i) begin
            if (!ready_q)                op      = OP_NOP;
            else if (write_i && read_i)  op      = OP_RW;
            else if (write_i)            op      = OP_WR;
            else if (cnt != 0)           op      = OP_RD;
            if (!ready_q || (read_i && !write_i && cnt == 0)) err_set = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) base[i] = slot_q[i];
        if (op == OP_RW && cnt != 0) begin
            base_cnt = cnt - 1;
            for (int i = 0; i < DEPTH - 1; i++) base[i] = slot_q[i+1];
            base[DEPTH-1] = '0;
        end
    end

    // Entries that the new key does not precede form a prefix; insert after it.
    always_comb begin
        pos = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < base_cnt && !new_first[i]) pos = i + 1;
        end
        ins[0] = (pos == 0) ? data_lt_i : base[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (i < pos)       ins[i] = base[i];
            else if (i == pos) ins[i] = data_lt_i;
            else               ins[i] = base[i-1];
        end
        ins[DEPTH] = (pos == DEPTH) ? data_lt_i : base[DEPTH-1];
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) slot_d[i] = slot_q[i];
        cnt_n   = cnt;
        rt_d    = rt_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        err_d   = err_q | err_set;
        ready_d = (op == OP_NOP);
        case (op)
            OP_WR, OP_RW: begin
                for (int i = 0; i < DEPTH; i++) slot_d[i] = ins[i];
                if (op == OP_WR && cnt == DEPTH) begin
                    rt_d = ins[DEPTH];
                    wr_d = 1'b1;
                end else begin
                    cnt_n = base_cnt + 1;
                end
            end
            OP_RD: begin
                for (int i = 0; i < DEPTH - 1; i++) slot_d[i] = slot_q[i+1];
                if (cnt == DEPTH && valid_rt_i) begin
                    slot_d[DEPTH-1] = data_rt_i;
                    rd_d            = 1'b1;
                end else begin
                    slot_d[DEPTH-1] = '0;
                    cnt_n           = cnt - 1;
                end
            end
            default: ;
        endcase
        // Unoccupied slots are kept zero so the head reads 0 when empty.
        for (int i = 0; i < DEPTH; i++) begin
            if (i >= cnt_n) slot_d[i] = '0;
        end
        count_d = CW'(cnt_n);
    end

    always_ff @(posedge clk) begin
        rst_q <= reset_i;
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            count_q <= '0;
            rt_q    <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
            count_q <= count_d;
            rt_q    <= rt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    assign reset_o    = rst_q;
    assign data_lt_o  = slot_q[0];
    assign valid_lt_o = (count_q != '0);
    assign data_rt_o  = rt_q;
    assign write_o    = wr_q;
    assign read_o     = rd_q;
    assign ready_o    = ready_q;
    assign count_o    = count_q;
    assign full_o     = (count_q == CW'(DEPTH));
    assign err_o      = err_q;

endmodule

// File: tb/tb_quick_node_p.sv
// Directed bench for quick_node_p: a min-first node plus a max-first node on shared inputs.
module tb_quick_node_p;

    logic        clk;
    logic        reset_i;
    logic        write_i;
    logic        read_i;
    logic [31:0] data_lt_i;
    logic [31:0] data_rt_i;
    logic        valid_rt_i;

    logic        reset_o,   m_reset_o;
    logic [31:0] data_lt_o, m_data_lt_o;
    logic        valid_lt_o, m_valid_lt_o;
    logic [31:0] data_rt_o, m_data_rt_o;
    logic        write_o,   m_write_o;
    logic        read_o,    m_read_o;
    logic        ready_o,   m_ready_o;
    logic [2:0]  count_o,   m_count_o;
    logic        full_o,    m_full_o;
    logic        err_o,     m_err_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    quick_node_p #(.KEY_W(16), .VAL_W(16), .DEPTH(4), .MIN_FIRST(1)) dut (
        .clk(clk), .reset_i(reset_i), .reset_o(reset_o),
        .write_i(write_i), .read_i(read_i), .data_lt_i(data_lt_i),
        .data_lt_o(data_lt_o), .valid_lt_o(valid_lt_o), .data_rt_o(data_rt_o),
        .write_o(write_o), .read_o(read_o), .data_rt_i(data_rt_i),
        .valid_rt_i(valid_rt_i), .ready_o(ready_o), .count_o(count_o),
        .full_o(full_o), .err_o(err_o)
    );

    quick_node_p #(.KEY_W(16), .VAL_W(16), .DEPTH(4), .MIN_FIRST(0)) dut_max (
        .clk(clk), .reset_i(reset_i), .reset_o(m_reset_o),
        .write_i(write_i), .read_i(read_i), .data_lt_i(data_lt_i),
        .data_lt_o(m_data_lt_o), .valid_lt_o(m_valid_lt_o), .data_rt_o(m_data_rt_o),
        .write_o(m_write_o), .read_o(m_read_o), .data_rt_i(data_rt_i),
        .valid_rt_i(valid_rt_i), .ready_o(m_ready_o), .count_o(m_count_o),
        .full_o(m_full_o), .err_o(m_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ent(input int k, input int v);
        logic [15:0] kk;
        logic [15:0] vv;
        kk = k[15:0];
        vv = v[15:0];
        return {kk, vv};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_cmd(input logic w, input logic r, input logic [31:0] d);
        @(negedge clk);
        write_i   = w;
        read_i    = r;
        data_lt_i = d;
        @(negedge clk);
        write_i   = 1'b0;
        read_i    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] head, input int cnt);
        check({tag, ".head"}, data_lt_o, head);
        check({tag, ".count"}, count_o, cnt);
    endtask

    task automatic check_evict(input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        check({tag, ".write_o"}, write_o, 1);
        check({tag, ".data_rt_o"}, data_rt_o, e);
    endtask

    initial begin
        reset_i    = 1'b1;
        write_i    = 1'b0;
        read_i     = 1'b0;
        data_lt_i  = '0;
        data_rt_i  = '0;
        valid_rt_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst.count", count_o, 0);
        check("rst.valid", valid_lt_o, 0);
        check("rst.data", data_lt_o, 0);
        check("rst.data_rt", data_rt_o, 0);
        check("rst.ready", ready_o, 1);
        check("rst.err", err_o, 0);
        check("rst.write_o", write_o, 0);
        check("rst.read_o", read_o, 0);
        check("rst.reset_o", reset_o, 1);
        reset_i = 1'b0;
        @(negedge clk);
        check("rst.reset_o_low", reset_o, 0);

        // Fill: 7,3,9,5 -> 3,5,7,9
        do_cmd(1, 0, ent(7, 'h107));
        check_head("fill7", ent(7, 'h107), 1);
        check("fill7.ready", ready_o, 0);
        do_cmd(1, 0, ent(3, 'h103));
        check_head("fill3", ent(3, 'h103), 2);
        do_cmd(1, 0, ent(9, 'h109));
        check_head("fill9", ent(3, 'h103), 3);
        do_cmd(1, 0, ent(5, 'h105));
        check_head("fill5", ent(3, 'h103), 4);
        check("fill5.full", full_o, 1);
        check("fill5.write_o", write_o, 0);
        check("fill5.err", err_o, 0);

        // Overflow: key 9 spills, then key 12 itself spills
        exp_q.push_back(ent(9, 'h109));
        do_cmd(1, 0, ent(4, 'h104));
        check_head("ovf4", ent(3, 'h103), 4);
        check_evict("ovf4");
        @(negedge clk);
        check("ovf4.write_o_low", write_o, 0);
        exp_q.push_back(ent(12, 'h10c));
        do_cmd(1, 0, ent(12, 'h10c));
        check_head("ovf12", ent(3, 'h103), 4);
        check_evict("ovf12");

        // Read with refill from the right head, then drain 4,5,7,9
        valid_rt_i = 1'b1;
        data_rt_i  = ent(9, 'h99);
        do_cmd(0, 1, '0);
        check_head("refill", ent(4, 'h104), 4);
        check("refill.read_o", read_o, 1);
        check("refill.write_o", write_o, 0);
        valid_rt_i = 1'b0;
        data_rt_i  = '0;
        do_cmd(0, 1, '0);
        check_head("drain1", ent(5, 'h105), 3);
        check("drain1.read_o", read_o, 0);
        do_cmd(0, 1, '0);
        check_head("drain2", ent(7, 'h107), 2);
        do_cmd(0, 1, '0);
        check_head("drain3", ent(9, 'h99), 1);
        do_cmd(0, 1, '0);
        check_head("drain4", 0, 0);
        check("drain4.valid", valid_lt_o, 0);
        check("drain4.err", err_o, 0);

        // Read on empty
        do_cmd(0, 1, '0);
        check("rdempty.err", err_o, 1);
        check("rdempty.count", count_o, 0);
        check("rdempty.valid", valid_lt_o, 0);
        do_reset();
        check("rst2.err", err_o, 0);

        // Replace: 2,6 then read+write key 1 -> 1,6
        do_cmd(1, 0, ent(2, 'h102));
        do_cmd(1, 0, ent(6, 'h106));
        do_cmd(1, 1, ent(1, 'h101));
        check_head("rw", ent(1, 'h101), 2);
        check("rw.write_o", write_o, 0);
        check("rw.read_o", read_o, 0);
        do_cmd(0, 1, '0);
        check_head("rw.next", ent(6, 'h106), 1);
        do_cmd(0, 1, '0);
        check_head("rw.empty", 0, 0);

        // Equal keys keep arrival order
        do_cmd(1, 0, ent(5, 'hA));
        do_cmd(1, 0, ent(5, 'hB));
        check_head("tie.first", ent(5, 'hA), 2);
        do_cmd(0, 1, '0);
        check_head("tie.second", ent(5, 'hB), 1);

        // Max-first ordering on the second node
        do_reset();
        do_cmd(1, 0, ent(1, 'h101));
        do_cmd(1, 0, ent(8, 'h108));
        check("max.head", m_data_lt_o, ent(8, 'h108));
        check("max.count", m_count_o, 2);
        check("min.head", data_lt_o, ent(1, 'h101));
        do_cmd(0, 1, '0);
        check("max.next", m_data_lt_o, ent(1, 'h101));
        check("min.next", data_lt_o, ent(8, 'h108));

        // Back-to-back writes: second one dropped
        do_reset();
        @(negedge clk);
        write_i   = 1'b1;
        data_lt_i = ent(7, 'h107);
        @(negedge clk);
        data_lt_i = ent(3, 'h103);
        @(negedge clk);
        write_i   = 1'b0;
        check_head("b2b", ent(7, 'h107), 1);
        check("b2b.err", err_o, 1);

        // Reset overrides a concurrent write
        @(negedge clk);
        reset_i   = 1'b1;
        write_i   = 1'b1;
        data_lt_i = ent(2, 'h102);
        @(negedge clk);
        reset_i   = 1'b0;
        write_i   = 1'b0;
        check("midrst.count", count_o, 0);
        check("midrst.err", err_o, 0);
        check("midrst.valid", valid_lt_o, 0);
        check("midrst.write_o", write_o, 0);
        check("midrst.reset_o", reset_o, 1);
        @(negedge clk);
        check("midrst.reset_o_low", reset_o, 0);
        check("midrst.count_hold", count_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/quick_node_p.md
Name: quick_node_p

Overview:
- Parametrised next-generation QuickQ node holding DEPTH sorted entries (key + payload) instead of a single register/RAM pair.
- Nodes chain left-to-right into a systolic priority queue. The leftmost node's left port is the queue interface.
- On overflow, the node evicts its last entry to the right neighbour. On dequeue, it refills from the right neighbour's head.
- Min-first or max-first ordering is selectable.

Parameters:
- KEY_W, 16, priority key width
- VAL_W, 16, payload width; entry width W = KEY_W+VAL_W, key in MSBs
- DEPTH, 4, entries per node (>=2)
- MIN_FIRST, 1, 1 = smallest key at head, 0 = largest key at head

Ports:
- clk  in  1  clock, single domain, rising edge
- reset_i  in  1  synchronous active-high reset
- reset_o  out  1  reset_i registered 1 cycle, drives right node's reset_i
- write_i  in  1  enqueue data_lt_i
- read_i  in  1  dequeue head
- data_lt_i  in  W  entry from left
- data_lt_o  out  W  head entry (slot 0), registered
- valid_lt_o  out  1  slot 0 valid
- data_rt_o  out  W  evicted entry to right, registered
- write_o  out  1  enqueue command to right, registered
- read_o  out  1  dequeue command to right, registered
- data_rt_i  in  W  right node's data_lt_o
- valid_rt_i  in  1  right node's valid_lt_o
- ready_o  out  1  node accepts a command this cycle
- count_o  out  $clog2(DEPTH+1)  occupied slots
- full_o  out  1  count_o == DEPTH
- err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset: all slots invalid; count_o=0; outputs write_o, read_o, err_o, valid_lt_o = 0; data outputs = 0; ready_o=1; reset_o=1 on the cycle after reset_i.
- Storage: slots[0..DEPTH-1] plus valid bits, kept sorted with head in slot 0.
- Ordering: "a precedes b" means key(a)<key(b) when MIN_FIRST=1, key(a)>key(b) when MIN_FIRST=0.
- Tie rule: on equal keys the older entry stays ahead (FIFO among equal keys).
- Issue rule: a command is accepted only when ready_o. ready_o = 0 in the cycle after any accepted command, so commands are spaced >=2 cycles apart and each command propagates one node per cycle.
  - A command arriving while !ready_o is ignored and sets err_o.
- Write only, not full: insert at the sorted position; count+1; no right traffic.
- Write only, full:
  - Insert at the sorted position; the entry that falls past slot DEPTH-1 (possibly the incoming one) goes to data_rt_o.
  - write_o=1 for exactly the next cycle; count unchanged.
- Read only, count>0:
  - Shift all slots left by one.
  - If full and valid_rt_i: slot DEPTH-1 <= data_rt_i; read_o=1 next cycle; count unchanged.
  - Otherwise count-1.
- Read only, count==0: ignored; set err_o.
- Read + write same cycle (replace):
  - Head removed; data_lt_i inserted into the remaining entries; count unchanged; no right traffic.
  - If count==0, behaves as a plain write.
- All state updates occur at the clock edge. data_lt_o/valid_lt_o reflect post-update slot 0 one cycle after the command.
- Latency: 1 cycle per node for write_o/read_o propagation.
- Reset mid-operation: reset_i overrides any command in the same cycle; pending write_o/read_o are cleared.

Decomposition:
- quickq_pkg: default KEY_W/VAL_W/DEPTH constants; op_e enum {OP_NOP, OP_WR, OP_RD, OP_RW} for the decoded command.
- Sub-module pq_cmp: combinational precedes(a,b) honouring MIN_FIRST; instantiated once per slot to form the insertion mask.

Test Plan (DEPTH=4, MIN_FIRST=1, key shown):
- Reset, then write keys 7,3,9,5 (2-cycle spacing) -> slots 3,5,7,9; full_o=1; data_lt_o key 3; no write_o.
- Full node, write key 4 -> slots 3,4,5,7; write_o pulse carrying key 9 one cycle later. Then write key 12 -> key 12 itself forwarded right.
- Full node 3,4,5,7 with valid_rt_i and right head 9, read -> slots 4,5,7,9; read_o pulse next cycle; count stays 4.
- Node 2,6 (count 2), read+write key 1 in the same cycle -> slots 1,6; count 2; no write_o/read_o.
- Equal keys: write (key 5,val A) then (key 5,val B) -> A at head, B second; with MIN_FIRST=0 and keys 1,8 -> head 8.
- Protocol:
  - Read on empty -> err_o=1 and state unchanged.
  - Back-to-back writes -> second ignored, err_o=1.
  - reset_i mid-stream -> count 0, err_o 0, reset_o high the next cycle.
